// File: rtl/prefetch_bus_unit.sv
// prefetch_bus_unit
//
// Memory-bus front end for the CPU core. One shared memory port is arbitrated
// between instruction prefetch into a DEPTH-entry queue and data accesses from
// the control unit. Data accesses have priority over prefetch. The memory is
// pipelined: the address is presented in cycle N and read data returns on
// data_in in cycle N+1. mem_ready=0 inserts wait states. A redirect flushes
// the queue and restarts fetching at redirect_pc.
//
// Ports:
//   clk_in, reset         clock; synchronous active-high reset
//   mem_req, address_out  bus request and address
//   READ_write, data_out  0=read / 1=write, and write data
//   data_in, mem_ready    read data (cycle after accept), accept/wait-state
//   fetch_valid/data/pc   head of the prefetch queue (all registered)
//   fetch_pop             consume the head byte
//   redirect, redirect_pc flush the queue and restart fetch at redirect_pc
//   dreq, dwrite, daddr,  data access request, held until dack
//   dwdata
//   dack, drdata          access-complete pulse and read result

module prefetch_bus_unit #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
    input  logic                  clk_in,
    input  logic                  reset,
    // Memory port
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  READ_write,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  mem_ready,
    // Instruction fetch side
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  fetch_pop,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    // Data access side
    input  logic                  dreq,
    input  logic                  dwrite,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dack,
    output logic [DATA_WIDTH-1:0] drdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0]         ptr_t;
    typedef logic [CW-1:0]         cnt_t;
    typedef logic [CW:0]           occ_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam occ_t DEPTH_OCC = occ_t'(DEPTH);

    logic [DATA_WIDTH-1:0] queue_mem [DEPTH];
    ptr_t  rd_ptr;
    ptr_t  wr_ptr;
    cnt_t  count;
    addr_t fetch_addr;
    addr_t head_pc;
    logic  fetch_inflight;
    logic  data_inflight;
    logic  inflight_epoch;
    logic  epoch;

    logic  issue_data;
    logic  issue_fetch;
    logic  accepted;
    logic  push;
    logic  pop;
    occ_t  occupancy;

    // Arbitration: redirect > data access > prefetch > idle. Everything here
    // is a function of registered state and the held request inputs, so a
    // stalled transfer keeps its address until it is accepted or pre-empted.
    always_comb begin
        // In-flight fetch counts against capacity so the queue can never overflow.
        occupancy   = {1'b0, count} + {{CW{1'b0}}, fetch_inflight};
        issue_data  = !reset && dreq && !data_inflight;
        issue_fetch = !reset && !redirect && !issue_data && (occupancy < DEPTH_OCC);

        mem_req     = issue_data || issue_fetch;
        READ_write  = issue_data && dwrite;
        address_out = issue_data ? daddr : fetch_addr;
        data_out    = dwdata;
        accepted    = mem_req && mem_ready;

        // A fetch launched before a redirect must never land in the new stream.
        push = fetch_inflight && (inflight_epoch == epoch) && !redirect;
        pop  = fetch_pop && (count != '0) && !redirect;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            fetch_addr     <= RESET_PC;
            head_pc        <= RESET_PC;
            fetch_inflight <= 1'b0;
            data_inflight  <= 1'b0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
        end else begin
            fetch_inflight <= accepted && issue_fetch;
            data_inflight  <= accepted && issue_data;
            // Prefetch never issues in a redirect cycle, so the current epoch
            // is always the right tag for a newly issued fetch.
            inflight_epoch <= epoch;

            if (redirect) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                fetch_addr <= redirect_pc;
                head_pc    <= redirect_pc;
                epoch      <= ~epoch;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + ptr_t'(1);
                    head_pc <= head_pc + addr_t'(1);
                end
                if (push && !pop) begin
                    count <= count + cnt_t'(1);
                end else if (pop && !push) begin
                    count <= count - cnt_t'(1);
                end
                if (accepted && issue_fetch) begin
                    fetch_addr <= fetch_addr + addr_t'(1);
                end
            end
        end
    end

    // Queue storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk_in) begin
        if (!reset && push) begin
            queue_mem[wr_ptr] <= data_in;
        end
    end

    always_comb begin
        fetch_valid = (count != '0);
        fetch_data  = queue_mem[rd_ptr];
        fetch_pc    = head_pc;
        dack        = data_inflight;
        drdata      = data_in;
    end

endmodule

// File: tb/tb_prefetch_bus_unit.sv
module tb_prefetch_bus_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0200;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] address_out;
    logic        READ_write;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        mem_ready;
    logic        fetch_valid;
    logic [7:0]  fetch_data;
    logic [15:0] fetch_pc;
    logic        fetch_pop;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        dreq;
    logic        dwrite;
    logic [15:0] daddr;
    logic [7:0]  dwdata;
    logic        dack;
    logic [7:0]  drdata;

    always #5 clk_in = ~clk_in;

    prefetch_bus_unit #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .mem_req     (mem_req),
        .address_out (address_out),
        .READ_write  (READ_write),
        .data_out    (data_out),
        .data_in     (data_in),
        .mem_ready   (mem_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_pc    (fetch_pc),
        .fetch_pop   (fetch_pop),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dreq        (dreq),
        .dwrite      (dwrite),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .dack        (dack),
        .drdata      (drdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queue of fetched PCs with the cycle each becomes visible.
    typedef struct {
        logic [15:0] pc;
        int          ready;
    } fent_t;

    fent_t       fq[$];
    logic [15:0] m_fetch_addr = RESET_PC;
    bit          m_dacc_prev  = 1'b0;
    bit          d_done       = 1'b0;
    bit          d_acked      = 1'b0;
    int          d_wait       = 0;
    bit          resp_read    = 1'b0;
    logic [15:0] resp_addr    = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents: low address byte, except one distinctive data word.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a == 16'h0020) ? 8'h5C : a[7:0];
    endfunction

    // Called mid-cycle: compare DUT outputs against the model, then advance it.
    task automatic evaluate();
        bit want_data;
        bit exp_valid;
        bit data_acc;
        bit fetch_acc;
        if (reset) begin
            fq.delete();
            m_fetch_addr = RESET_PC;
            m_dacc_prev  = 1'b0;
            d_done       = 1'b0;
            resp_read    = 1'b0;
            return;
        end

        check_eq("dack", 32'(dack), 32'(m_dacc_prev));
        if (m_dacc_prev) begin
            d_acked = 1'b1;
            if (!dwrite) check_eq("drdata", 32'(drdata), 32'(mem_byte(daddr)));
        end

        exp_valid = (fq.size() > 0) && (fq[0].ready <= cyc);
        check_eq("fetch_valid", 32'(fetch_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("fetch_pc", 32'(fetch_pc), 32'(fq[0].pc));
            check_eq("fetch_data", 32'(fetch_data), 32'(mem_byte(fq[0].pc)));
        end

        want_data = dreq && !d_done;
        data_acc  = 1'b0;
        fetch_acc = 1'b0;
        if (want_data) begin
            check_eq("data_req", 32'(mem_req), 1);
            check_eq("data_addr", 32'(address_out), 32'(daddr));
            check_eq("data_rw", 32'(READ_write), 32'(dwrite));
            if (dwrite) check_eq("data_wdata", 32'(data_out), 32'(dwdata));
            data_acc = mem_ready;
        end else if (!redirect && fq.size() < DEPTH) begin
            check_eq("pf_req", 32'(mem_req), 1);
            check_eq("pf_rw", 32'(READ_write), 0);
            check_eq("pf_addr", 32'(address_out), 32'(m_fetch_addr));
            fetch_acc = mem_ready;
        end else begin
            check_eq("idle_req", 32'(mem_req), 0);
        end

        // The bench memory answers whatever the bus actually presented.
        resp_read = mem_req && mem_ready && !READ_write;
        resp_addr = address_out;

        if (data_acc) d_done = 1'b1;
        m_dacc_prev = data_acc;
        if (exp_valid && fetch_pop && !redirect) void'(fq.pop_front());
        if (fetch_acc) begin
            fq.push_back('{pc: m_fetch_addr, ready: cyc + 2});
            m_fetch_addr = m_fetch_addr + 16'd1;
        end
        if (redirect) begin
            fq.delete();
            m_fetch_addr = redirect_pc;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk_in);
        evaluate();
        @(posedge clk_in);
        #1;
        cyc++;
        data_in = resp_read ? mem_byte(resp_addr) : 8'($urandom);
        if (reset || d_acked) begin
            dreq    = 1'b0;
            d_done  = 1'b0;
            d_acked = 1'b0;
            d_wait  = 0;
        end else if (dreq) begin
            d_wait++;
            check_eq("dack_timeout", 32'(d_wait > 50), 0);
            if (d_wait > 50) begin
                dreq   = 1'b0;
                d_done = 1'b0;
                d_wait = 0;
            end
        end
    endtask

    task automatic start_dreq(input bit wr, input logic [15:0] a, input logic [7:0] wd);
        dreq   = 1'b1;
        dwrite = wr;
        daddr  = a;
        dwdata = wd;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) run_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        data_in     = '0;
        mem_ready   = 1'b1;
        fetch_pop   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dreq        = 1'b0;
        dwrite      = 1'b0;
        daddr       = '0;
        dwdata      = '0;

        // Fill from reset with no consumer; bus goes idle once the queue is full.
        do_reset(2);
        repeat (8) run_cycle();
        check_eq("fill_idle", 32'(mem_req), 0);
        check_eq("fill_head_pc", 32'(fetch_pc), 32'(RESET_PC));

        // Continuous pop from reset: one byte per cycle after the first.
        do_reset(1);
        fetch_pop = 1'b1;
        repeat (12) run_cycle();

        // Redirect while the fetch of 0x0203 is in flight; stream wraps at 0xFFFF.
        fetch_pop = 1'b0;
        do_reset(1);
        repeat (4) run_cycle();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        run_cycle();
        redirect  = 1'b0;
        fetch_pop = 1'b1;
        repeat (8) run_cycle();

        // Data write pre-empts prefetch.
        start_dreq(1'b1, 16'h0010, 8'hAB);
        repeat (6) run_cycle();

        // Data read stalled by three wait states.
        mem_ready = 1'b0;
        start_dreq(1'b0, 16'h0020, 8'h00);
        repeat (3) run_cycle();
        check_eq("stall_addr", 32'(address_out), 32'h0020);
        mem_ready = 1'b1;
        repeat (4) run_cycle();

        // Reset with a data read in flight.
        fetch_pop = 1'b0;
        start_dreq(1'b0, 16'h0020, 8'h00);
        run_cycle();
        do_reset(1);
        check_eq("post_reset_dack", 32'(dack), 0);
        check_eq("post_reset_valid", 32'(fetch_valid), 0);
        check_eq("post_reset_addr", 32'(address_out), 32'(RESET_PC));
        repeat (6) run_cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            mem_ready   = ($urandom_range(0, 3) != 0);
            fetch_pop   = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            reset       = ($urandom_range(0, 299) == 0);
            if (!dreq && $urandom_range(0, 5) == 0) begin
                start_dreq(1'($urandom_range(0, 1)),
                           ($urandom_range(0, 1) != 0) ? 16'h0020 : 16'($urandom),
                           8'($urandom));
            end
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prefetch_bus_unit.md
Name: prefetch_bus_unit

Overview:
- Parametrised memory-bus front end for the CPU core. It replaces the single-byte data-in latch with a DEPTH-entry instruction prefetch queue.
- Arbitrates one shared memory port between opcode/operand prefetch and control-unit data accesses. Data accesses have priority.
- Supports pipelined synchronous memory: address in cycle N, read data on data_in in cycle N+1. Supports wait states via mem_ready.
- Handles control-flow redirects (branch/jump/reset vector) by flushing the queue and discarding stale in-flight fetches.

Parameters:
- DATA_WIDTH, 8, bus/queue data width.
- ADDR_WIDTH, 16, address width.
- DEPTH, 4, prefetch queue entries; power of two, >=2.
- RESET_PC, 16'h0000, fetch address after reset (ADDR_WIDTH bits).

Ports:
- clk_in  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  a bus transfer is presented this cycle.
- address_out  out  ADDR_WIDTH  bus address.
- READ_write  out  1  0=read, 1=write (valid when mem_req).
- data_out  out  DATA_WIDTH  write data (valid when mem_req && READ_write).
- data_in  in  DATA_WIDTH  read data, valid the cycle after an accepted read.
- mem_ready  in  1  transfer presented this cycle is accepted; 0 = wait state, hold request.
- fetch_valid  out  1  queue head valid.
- fetch_data  out  DATA_WIDTH  queue head byte.
- fetch_pc  out  ADDR_WIDTH  address of queue head byte.
- fetch_pop  in  1  consume head; ignored when !fetch_valid.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- dreq  in  1  data access request; held until dack.
- dwrite  in  1  1=write, 0=read; stable while dreq.
- daddr  in  ADDR_WIDTH  data address; stable while dreq.
- dwdata  in  DATA_WIDTH  write data; stable while dreq.
- dack  out  1  one-cycle pulse: data access complete.
- drdata  out  DATA_WIDTH  read result, valid with dack on a read (equals data_in that cycle).

Behaviour:
- State:
  - queue storage with rd/wr pointers and count (0..DEPTH);
  - fetch_addr (next prefetch address) and head_pc;
  - in-flight flag pair fetch_inflight/data_inflight with the in-flight kind;
  - epoch bit.
- Reset (sync) sets:
  - count=0, pointers=0, fetch_addr=head_pc=RESET_PC;
  - in-flight flags cleared; outputs fetch_valid=0, dack=0, mem_req=0.
  - Any response arriving the cycle after reset is discarded.
- Arbitration, evaluated combinationally each cycle. Priority order:
  1. redirect;
  2. data access when dreq && !data_inflight;
  3. prefetch when count + fetch_inflight < DEPTH;
  4. idle (mem_req=0, READ_write=0, address_out=fetch_addr).
- Redirect cycle:
  - no prefetch is issued; a data access may still issue;
  - next-state: count=0, pointers=0, fetch_addr=head_pc=redirect_pc, epoch toggles;
  - a fetch response arriving next cycle is dropped.
- Transfer acceptance: a transfer is accepted when mem_req && mem_ready. If mem_ready=0, address_out, READ_write and data_out hold, and arbitration is re-evaluated next cycle; a newly arriving dreq may pre-empt a stalled prefetch.
- Accepted prefetch: fetch_addr increments modulo 2^ADDR_WIDTH. Next cycle, data_in is pushed to the queue if the epoch matches.
- Accepted data access: data_inflight is set. Next cycle, dack=1 and, for reads, drdata=data_in; data_inflight clears.
- Latency:
  - fetch: first fetch_valid 2 cycles after reset deasserts (issue cycle + return cycle), with mem_ready=1;
  - data: dack exactly 1 cycle after acceptance.
- Queue operations:
  - push and pop in the same cycle leave count unchanged;
  - the issue gate makes overflow impossible;
  - pop on empty has no effect;
  - redirect with pop in the same cycle: redirect wins.
- On pop, head_pc increments modulo 2^ADDR_WIDTH.
- fetch_data/fetch_pc come from registered state (no combinational path from data_in).
- With continuous pop, mem_ready=1 and no data traffic, throughput is 1 byte/cycle after fill.

Test Plan:
1. RESET_PC=0x0200; memory returns low address byte; mem_ready=1; no pop -> addresses 0x0200..0x0203 issued; then mem_req=0. fetch_valid rises 2 cycles after reset with fetch_data=0x00, fetch_pc=0x0200. Count settles at 4.
2. Same setup with fetch_pop held high -> fetch_pc 0x0200,0x0201,... every cycle with no bubbles after the first valid.
3. Redirect to 0xFFFE while the fetch of 0x0203 is in flight -> the 0x03 byte is never visible. Next valid heads are 0xFFFE, 0xFFFF, then wrap to 0x0000 with fetch_pc wrapping.
4. Assert dreq with dwrite=1, daddr=0x0010, dwdata=0xAB during prefetch -> next bus cycle shows address_out=0x0010, READ_write=1, data_out=0xAB. dack pulses once the following cycle, then prefetch resumes at the interrupted fetch_addr.
5. Data read of 0x0020 (memory holds 0x5C) with mem_ready=0 for 3 cycles -> address_out held at 0x0020 for 4 cycles. dack=1 with drdata=0x5C one cycle after mem_ready rises. No queue push occurs during the stall.
6. Assert reset while one fetch and one data read are in flight -> next cycle dack=0, fetch_valid=0, count=0. The first new fetch address is RESET_PC.
